// File: rtl/cic_i_pkg.sv
// cic_i_pkg: shared width helpers and types for the CIC interpolator.
package cic_i_pkg;

  // Width of the phase counter; the top checks that its RATE_DW matches.
  localparam int unsigned CIC_I_RATE_DW = 16;

  typedef logic [CIC_I_RATE_DW-1:0] cic_i_phase_t;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int cic_i_clog2(input longint unsigned value);
    longint unsigned x;
    int              bits;
    x    = 64'd1;
    bits = 32'sd0;
    while (x < value) begin
      x    = x << 1;
      bits = bits + 32'sd1;
    end
    return bits;
  endfunction

  // Full-precision internal width: INP_DW + clog2((R*M)**N / R).
  function automatic int cic_i_width(input int inp_dw, input int rmax, input int nstg,
                                     input int mdly);
    longint unsigned prod;
    prod = 64'd1;
    for (int i = 0; i < nstg; i++) begin
      prod = prod * longint'(rmax * mdly);
    end
    return inp_dw + cic_i_clog2(prod / longint'(rmax));
  endfunction

endpackage

// File: rtl/cic_i_comb.sv
// cic_i_comb: one comb stage. The M-deep delay line advances only when a
// new input-rate sample is accepted; the difference is combinational.
module cic_i_comb
  import cic_i_pkg::*;
#(
  parameter int W = 20,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [M-1:0][W-1:0] dly_r;

  // Delay line: shift in the stage input on each accepted sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_r <= '0;
    end else if (en) begin
      dly_r[0] <= din;
      for (int k = 1; k < M; k++) begin
        dly_r[k] <= dly_r[k-1];
      end
    end
  end

  // Two's-complement wrap in the difference is intended.
  assign dout = din - dly_r[M-1];

endmodule

// File: rtl/cic_i.sv
// cic_i: CIC interpolator. N combs at input rate, zero-stuffing upsampler by
// R, N integrators at output rate, registered AXI-stream-style output.
// Optional feature: define CIC_I_VARIABLE_RATE_EN to enable the runtime rate
// port; without it the rate inputs are ignored and R is fixed at CIC_R.
module cic_i
  import cic_i_pkg::*;
#(
  parameter int INP_DW  = 16,
  parameter int OUT_DW  = 20,
  parameter int RATE_DW = 16,
  parameter int CIC_R   = 4,
  parameter int CIC_N   = 3,
  parameter int CIC_M   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INP_DW-1:0]  s_axis_in_tdata,
  input  logic               s_axis_in_tvalid,
  output logic               s_axis_in_tready,
  input  logic [RATE_DW-1:0] s_axis_rate_tdata,
  input  logic               s_axis_rate_tvalid,
  output logic [OUT_DW-1:0]  m_axis_out_tdata,
  output logic               m_axis_out_tvalid,
  input  logic               m_axis_out_tready
);

  localparam int W = cic_i_width(INP_DW, CIC_R, CIC_N, CIC_M);

  if (OUT_DW > W) begin : g_chk_out_dw
    $error("cic_i: OUT_DW exceeds the internal width W");
  end
  if (RATE_DW != CIC_I_RATE_DW) begin : g_chk_rate_dw
    $error("cic_i: RATE_DW must match the package phase counter width");
  end

  // Control
  cic_i_phase_t         phase_r;
  cic_i_phase_t         phase_nxt_s;
  logic [RATE_DW-1:0]   eff_rate_s;
  logic                 advance_s;
  logic                 phase_zero_s;
  logic                 phase_last_s;
  logic                 step_s;
  logic                 accept_s;

  // Datapath
  logic [CIC_N:0][W-1:0]   comb_s;
  logic [W-1:0]            ups_r;
  logic [CIC_N-1:0][W-1:0] acc_r;
  logic                    v_ups_r;
  logic [CIC_N-1:0]        v_r;
  logic [OUT_DW-1:0]       out_data_r;
  logic                    out_valid_r;

`ifdef CIC_I_VARIABLE_RATE_EN
  logic [RATE_DW-1:0] cur_rate_r;
  logic [RATE_DW-1:0] pend_rate_r;
  logic               pend_valid_r;
  logic               rate_ok_s;

  assign rate_ok_s = (s_axis_rate_tdata != RATE_DW'(0)) &&
                     (s_axis_rate_tdata <= RATE_DW'(CIC_R));

  // A pending rate takes effect on the phase-0 step itself, so the wrap
  // point of that very step already uses the new ratio.
  assign eff_rate_s = (accept_s && pend_valid_r) ? pend_rate_r : cur_rate_r;

  // Rate bookkeeping: a fresh strobe overrides the one being applied now.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_rate_r   <= RATE_DW'(CIC_R);
      pend_rate_r  <= RATE_DW'(CIC_R);
      pend_valid_r <= 1'b0;
    end else begin
      if (accept_s && pend_valid_r) begin
        cur_rate_r <= pend_rate_r;
      end
      if (s_axis_rate_tvalid && rate_ok_s) begin
        pend_rate_r  <= s_axis_rate_tdata;
        pend_valid_r <= 1'b1;
      end else if (accept_s) begin
        pend_valid_r <= 1'b0;
      end
    end
  end
`else
  logic unused_rate_s;

  assign unused_rate_s = ^{s_axis_rate_tdata, s_axis_rate_tvalid};
  assign eff_rate_s    = RATE_DW'(CIC_R);
`endif

  // Handshake qualification and next phase.
  always_comb begin
    advance_s    = !out_valid_r || m_axis_out_tready;
    phase_zero_s = (phase_r == cic_i_phase_t'(0));
    step_s       = advance_s && (!phase_zero_s || s_axis_in_tvalid);
    accept_s     = step_s && phase_zero_s;
    phase_last_s = (phase_r == cic_i_phase_t'(eff_rate_s - RATE_DW'(1)));
    if (phase_last_s) begin
      phase_nxt_s = cic_i_phase_t'(0);
    end else begin
      phase_nxt_s = phase_r + cic_i_phase_t'(1);
    end
  end

  assign s_axis_in_tready = advance_s && phase_zero_s && !reset;

  // Input sample sign-extended to the full internal width feeds the combs.
  assign comb_s[0] = W'($signed(s_axis_in_tdata));

  for (genvar j = 0; j < CIC_N; j++) begin : g_comb
    cic_i_comb #(
      .W (W),
      .M (CIC_M)
    ) u_comb (
      .clk   (clk),
      .reset (reset),
      .en    (accept_s),
      .din   (comb_s[j]),
      .dout  (comb_s[j+1])
    );
  end

  // Phase counter: advances on every step, wraps at the effective rate.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r <= cic_i_phase_t'(0);
    end else if (step_s) begin
      phase_r <= phase_nxt_s;
    end
  end

  // Upsampler and integrator chain: all stages move together on a step.
  always_ff @(posedge clk) begin
    if (reset) begin
      ups_r   <= '0;
      acc_r   <= '0;
      v_ups_r <= 1'b0;
      v_r     <= '0;
    end else if (step_s) begin
      ups_r    <= phase_zero_s ? comb_s[CIC_N] : W'(0);
      v_ups_r  <= 1'b1;
      acc_r[0] <= acc_r[0] + ups_r;
      v_r[0]   <= v_ups_r;
      for (int i = 1; i < CIC_N; i++) begin
        acc_r[i] <= acc_r[i] + acc_r[i-1];
        v_r[i]   <= v_r[i-1];
      end
    end
  end

  // Output register: loads on a step, valid drops once consumed otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (step_s) begin
      out_data_r  <= acc_r[CIC_N-1][W-1 -: OUT_DW];
      out_valid_r <= v_r[CIC_N-1];
    end else if (m_axis_out_tready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign m_axis_out_tdata  = out_data_r;
  assign m_axis_out_tvalid = out_valid_r;

endmodule

// File: doc/cic_i.md
Name: cic_i

Overview:
- CIC interpolator: the transmit-side counterpart of the team's CIC decimator.
- Chain order: CIC_N comb stages at input rate, then a zero-stuffing upsampler by R, then CIC_N integrators at output rate, then an output register.
- AXI-stream-style in/out with back-pressure. Runtime-variable rate R up to CIC_R.

Parameters:
INP_DW, 16, input sample width (signed)
OUT_DW, 20, output sample width (signed); must be <= W
RATE_DW, 16, rate port width
CIC_R, 4, maximum (and reset) interpolation ratio, >= 1
CIC_N, 3, number of comb and integrator stages, >= 1
CIC_M, 1, comb differential delay, >= 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axis_in_tdata  in  INP_DW  signed input sample
s_axis_in_tvalid  in  1  input valid
s_axis_in_tready  out  1  input ready
s_axis_rate_tdata  in  RATE_DW  requested rate R
s_axis_rate_tvalid  in  1  rate strobe
m_axis_out_tdata  out  OUT_DW  signed output sample
m_axis_out_tvalid  out  1  output valid
m_axis_out_tready  in  1  output ready

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Internal width W = INP_DW + clog2((CIC_R*CIC_M)**CIC_N / CIC_R).
  - All comb and integrator registers are W bits, full precision, no pruning.
  - Input is sign-extended to W.
  - Two's-complement wrap is intended.
  - Elaboration error if OUT_DW > W.
- advance = !m_axis_out_tvalid || m_axis_out_tready.
- step = advance && (phase != 0 || s_axis_in_tvalid).
- s_axis_in_tready = advance && phase == 0 (combinational). Acceptance = tvalid && tready, which equals step at phase 0.
- Phase counter: runs 0..current_R-1 and advances on step, wrapping to 0. With current_R == 1 the phase stays 0.
- Combs:
  - Chain is combinational on the accepted sample: c_j = c_{j-1} - delay_j[M-1].
  - Each comb's M-deep delay line shifts only on acceptance.
- Upsampler register ups, on step: loads comb output at phase 0, loads 0 otherwise.
- Integrators: acc_0 += ups, acc_i += acc_{i-1} (registered values), all on step only.
- Valid tracking:
  - Valid bits v_ups, v_0..v_{N-1} shift on step; v_ups <= 1.
  - Output register loads acc_{N-1}[W-1 -: OUT_DW] on step.
  - m_axis_out_tvalid <= v_{N-1} on step; else cleared when m_axis_out_tready; else held.
- Latency: sample accepted at edge t produces its first output contribution visible at edge t+N+2 (no stalls). First valid output after N+2 steps.
- Starvation: phase 0 with no input gives no step. All state holds; output valid drops once consumed.
- Back-pressure: tvalid && !tready freezes all state, and data stays stable.
- Rate changes:
  - s_axis_rate_tvalid latches the value into pending_R, setting pending flag.
  - Applied (current_R <= pending_R) at the next step where phase == 0, before the phase update.
  - Values 0 or > CIC_R are ignored.
  - Gain is not normalised: DC gain = current_R**(N-1) * CIC_M**N.
- Simultaneous rate strobe and apply on the same edge: the new strobe wins, becoming pending for the next boundary.
- Reset (including mid-stream) clears:
  - all combs, ups, accumulators and valid bits; phase = 0; pending flag;
  - outputs tdata = 0, tvalid = 0, tready = 0 during reset.
  - current_R = CIC_R.

Optional Feature:
- Macro CIC_I_VARIABLE_RATE_EN.
  - Defined: runtime rate port is active as described.
  - Undefined: rate ports are ignored, current_R is fixed at CIC_R, and pending logic is not built.

Decomposition:
- Package cic_i_pkg holds:
  - function cic_i_width(INP_DW, R, N, M) returning W;
  - a clog2 helper;
  - typedef for the phase counter (RATE_DW bits).
- One natural sub-module: cic_i_comb, a single comb stage with an M-deep enabled delay line and combinational difference output.
- Integrators, upsampler and control stay in the top.

Test Plan:
- Impulse response, R=4, N=3, M=1, INP_DW=16, OUT_DW=20, tready=1: input 1 then zeros -> output 1,3,6,10,12,12,10,6,3,1 then zeros; first nonzero 5 edges after acceptance.
- DC response: constant input 1 -> steady output 16; input -32768 -> steady -524288; s_axis_in_tready high exactly 1 cycle in 4.
- Runtime rate, macro defined: rate 2 mid-stream -> applied at next phase-0 boundary; impulse -> 1,3,3,1; DC 1 -> 4. Rate 0 or 5 -> ignored.
- Back-pressure and starvation: random m_axis_out_tready and gaps in s_axis_in_tvalid -> output sequence identical to the uninterrupted run; tdata stable while tvalid && !tready.
- Reset mid-stream: assert reset during ramp -> next edge all outputs 0, current_R = 4; restart impulse -> same sequence as the first test.
- Macro undefined: rate strobes of 2 -> ignored; impulse response unchanged, as in the first test.
